rr_channel_scheduler: RTL and testbench
=======================================

// Module: rr_channel_scheduler
// PURPOSE
//  Round-robin scheduler that shares one registered output channel between NUM_CHANNELS
//  valid/ready input channels. Each accepted word is widened to CHANNEL_WIDTH_OUT and
//  tagged with its source index. Sits between per-unit output channels and the
//  shared inter-FPGA/host link.
//  Replaces fixed lowest-index priority with fair round-robin, plus optional burst locking.
// PARAMETERS
//  NUM_CHANNELS      2   number of input channels (>=1)
//  CHANNEL_WIDTH_IN  32  payload width per input channel
//  CHANNEL_WIDTH_OUT 64  output word width
//  TAG_MSB           55  MSB of source-index tag field in out_data
//  TAG_LSB           48  LSB of source-index tag field in out_data
//  MAX_BURST         4   max consecutive words per grant (RR_BURST_LOCK_EN only; >=1)
// PORTS
//  clk        in   1                          clock
//  reset      in   1                          synchronous, active-low reset
//  in_data    in   CHANNEL_WIDTH_IN*NUM_CHANNELS  channel i at [i*CHANNEL_WIDTH_IN +: CHANNEL_WIDTH_IN]
//  in_valid   in   NUM_CHANNELS               per-channel valid
//  in_ready   out  NUM_CHANNELS               per-channel ready, at most one bit high (onehot0)
//  out_data   out  CHANNEL_WIDTH_OUT          registered tagged word
//  out_valid  out  1                          registered valid
//  out_ready  in   1                          downstream ready
//  last_grant out  $clog2(NUM_CHANNELS) (min 1)   index of last accepted channel
//  idle       out  1                          out_valid==0 && in_valid==0
// BEHAVIOUR
//  - Reset (reset==0 at posedge): out_valid=0, out_data=0, last_grant=NUM_CHANNELS-1,
//    burst_cnt=0, lock=0. in_ready is forced 0 while reset==0.
//  - load_en = !out_valid || out_ready. in_ready[g] = load_en && in_valid[g] for granted g.
//    in_ready is combinational; all other outputs are registered.
//  - Transfer on channel i when in_valid[i] && in_ready[i]. Output is updated next edge.
//    Latency is 1 cycle. Full throughput is 1 word/cycle when out_ready stays 1.
//  - Grant (not locked): search from (last_grant+1) mod NUM_CHANNELS upward, with wrap.
//    The first channel with valid set wins. If no channel is valid, there is no grant.
//  - On transfer: last_grant<=i.
//    out_data <= 0 | in word in [CHANNEL_WIDTH_IN-1:0] | i zero-extended in [TAG_MSB:TAG_LSB].
//    Bits outside these two fields are 0.
//  - out_valid && !out_ready: out_data and out_valid are held stable, and in_ready is 0.
//  - Output handshake: when out_valid && out_ready and no new transfer occurs, out_valid<=0.
//  - Width rules: CHANNEL_WIDTH_IN<=TAG_LSB, TAG_MSB<CHANNEL_WIDTH_OUT, and
//    TAG_MSB-TAG_LSB+1 >= $clog2(NUM_CHANNELS). A violation triggers an elaboration $error.
//  - NUM_CHANNELS==1: grant is always channel 0 and the tag is 0.
//  - Input sources hold valid until ready. The scheduler rechecks grants every cycle,
//    so dropping valid without a transfer is tolerated and causes re-arbitration.
//  - idle <= (out_valid_next==0) && (in_valid==0), registered. It is 1 after reset.
// CONFIGURATION
//  RR_BURST_LOCK_EN defined:
//  - State ARB/LOCK and burst_cnt, width $clog2(MAX_BURST+1).
//  - After a transfer on channel c in ARB: if MAX_BURST>1, go to LOCK on c with burst_cnt=1.
//  - In LOCK, c is granted exclusively while in_valid[c]. Each transfer increments burst_cnt.
//  - Return to ARB in these cases:
//      * burst_cnt reaches MAX_BURST; the next grant starts from c+1.
//      * in_valid[c]==0 in any LOCK cycle; release happens the same cycle, so that
//        cycle arbitrates round-robin from c+1 with no bubble.
//  - Backpressure (load_en==0) freezes LOCK and burst_cnt.
//  RR_BURST_LOCK_EN undefined: no LOCK state. Arbitration is re-run on every word and
//  MAX_BURST is ignored.
// TESTING
//  T1 reset=0 for 2 cycles with in_valid=2'b11 -> in_ready=0, out_valid=0, out_data=0, idle=1.
//  T2 (no macro) in_valid=2'b11 held, out_ready=1 -> tags 0,1,0,1...
//     out_valid=1 from cycle 1 on, no bubbles.
//  T3 Hold ch0 word 0xA5A5A5A5 in out reg, out_ready=0 for 3 cycles
//     -> out_data=0x0000_0000_A5A5_A5A5 stable, in_ready=0.
//     Then out_ready=1 -> each word is delivered exactly once, with no loss or duplicate.
//  T4 (RR_BURST_LOCK_EN, MAX_BURST=4) both valid, out_ready=1
//     -> tag sequence 0,0,0,0,1,1,1,1,0...
//  T5 (RR_BURST_LOCK_EN) ch0 valid for 2 words then low, ch1 valid -> tags 0,0,1 back to back.
//     The release occurs with no idle cycle.
//  T6 reset=0 mid-burst (2nd of 4 words) -> out_valid=0 next cycle.
//     After release, the first grant is ch0 with a fresh burst_cnt.

Source files
------------

// File: rtl/rr_channel_scheduler.sv
// rr_channel_scheduler: round-robin arbiter sharing one registered output channel
// between NUM_CHANNELS valid/ready inputs. Each accepted word is zero-extended to
// CHANNEL_WIDTH_OUT and tagged with its source index in [TAG_MSB:TAG_LSB].
// Optional feature macro: RR_BURST_LOCK_EN. When it is defined, a granted channel
// keeps the grant for up to MAX_BURST consecutive words.
module rr_channel_scheduler #(
  parameter int NUM_CHANNELS      = 2,
  parameter int CHANNEL_WIDTH_IN  = 32,
  parameter int CHANNEL_WIDTH_OUT = 64,
  parameter int TAG_MSB           = 55,
  parameter int TAG_LSB           = 48,
  parameter int MAX_BURST         = 4
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset,
  input  logic [CHANNEL_WIDTH_IN*NUM_CHANNELS-1:0]   i_in_data,
  input  logic [NUM_CHANNELS-1:0]                    i_in_valid,
  output logic [NUM_CHANNELS-1:0]                    o_in_ready,
  output logic [CHANNEL_WIDTH_OUT-1:0]               o_out_data,
  output logic                                       o_out_valid,
  input  logic                                       i_out_ready,
  output logic [(NUM_CHANNELS>1 ? $clog2(NUM_CHANNELS) : 1)-1:0] o_last_grant,
  output logic                                       o_idle
);

  localparam int GW       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TW       = TAG_MSB - TAG_LSB + 1;
  localparam int TAG_NEED = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 0;

  // Elaboration-time parameter sanity checks
  if (NUM_CHANNELS < 1) begin : g_chk_n
    $error("rr_channel_scheduler: NUM_CHANNELS must be >= 1");
  end
  if (MAX_BURST < 1) begin : g_chk_burst
    $error("rr_channel_scheduler: MAX_BURST must be >= 1");
  end
  if (TAG_MSB < TAG_LSB) begin : g_chk_tag_order
    $error("rr_channel_scheduler: TAG_MSB must be >= TAG_LSB");
  end
  if (CHANNEL_WIDTH_IN > TAG_LSB) begin : g_chk_in_w
    $error("rr_channel_scheduler: payload overlaps tag field");
  end
  if (TAG_MSB >= CHANNEL_WIDTH_OUT) begin : g_chk_out_w
    $error("rr_channel_scheduler: tag field exceeds output width");
  end
  if (TW < TAG_NEED) begin : g_chk_tag_w
    $error("rr_channel_scheduler: tag field too narrow for channel index");
  end

  logic [CHANNEL_WIDTH_OUT-1:0] r_out_data;
  logic                         r_out_valid;
  logic [GW-1:0]                r_last_grant;
  logic                         r_idle;

  logic                         w_load_en;
  logic                         w_rr_hit;
  logic [GW-1:0]                w_rr_gnt;
  logic                         w_lock_hold;
  logic                         w_hit;
  logic [GW-1:0]                w_gnt;
  logic [CHANNEL_WIDTH_IN-1:0]  w_word;
  logic [CHANNEL_WIDTH_OUT-1:0] w_out_word;
  logic                         w_xfer;
  logic                         w_out_valid_nxt;

  // Round-robin search starting one past the last granted channel, with wrap
  always_comb begin
    int idx;
    idx      = 0;
    w_rr_hit = 1'b0;
    w_rr_gnt = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_CHANNELS;
      if (!w_rr_hit && i_in_valid[idx]) begin
        w_rr_hit = 1'b1;
        w_rr_gnt = GW'(idx);
      end
    end
  end

`ifdef RR_BURST_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic          r_lock;
  logic [BW-1:0] r_burst_cnt;

  // A lock only holds while its channel keeps valid; otherwise it falls back to RR
  assign w_lock_hold = r_lock && i_in_valid[r_last_grant];

  // Burst lock state: enter on an arbitrated transfer, count locked words,
  // release at MAX_BURST or when the locked channel drops valid
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_lock      <= 1'b0;
      r_burst_cnt <= '0;
    end else if (w_load_en) begin
      if (w_xfer && w_lock_hold) begin
        if (r_burst_cnt == BW'(MAX_BURST - 1)) begin
          r_lock      <= 1'b0;
          r_burst_cnt <= '0;
        end else begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
      end else if (w_xfer) begin
        if (MAX_BURST > 1) begin
          r_lock      <= 1'b1;
          r_burst_cnt <= BW'(1);
        end else begin
          r_lock      <= 1'b0;
          r_burst_cnt <= '0;
        end
      end else begin
        r_lock      <= 1'b0;
        r_burst_cnt <= '0;
      end
    end
  end
`else
  assign w_lock_hold = 1'b0;
`endif

  // Final grant: locked channel takes precedence over the round-robin pick
  always_comb begin
    w_hit = w_lock_hold || w_rr_hit;
    w_gnt = w_lock_hold ? r_last_grant : w_rr_gnt;
  end

  // Select the granted payload and build the tagged output word
  always_comb begin
    w_word     = '0;
    w_out_word = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (w_gnt == GW'(i)) w_word = i_in_data[i*CHANNEL_WIDTH_IN +: CHANNEL_WIDTH_IN];
    end
    w_out_word[CHANNEL_WIDTH_IN-1:0] = w_word;
    w_out_word[TAG_MSB:TAG_LSB]      = TW'(w_gnt);
  end

  assign w_load_en       = !r_out_valid || i_out_ready;
  assign w_xfer          = i_reset && w_load_en && w_hit;
  assign w_out_valid_nxt = w_xfer || (r_out_valid && !i_out_ready);

  // One-hot ready to the granted channel only when the output register can load
  always_comb begin
    o_in_ready = '0;
    if (w_xfer) o_in_ready[w_gnt] = 1'b1;
  end

  // Output register, last-grant pointer and idle flag
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_last_grant <= GW'(NUM_CHANNELS - 1);
      r_idle       <= 1'b1;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      if (w_xfer) begin
        r_out_data   <= w_out_word;
        r_last_grant <= w_gnt;
      end
      r_idle <= !w_out_valid_nxt && (i_in_valid == '0);
    end
  end

  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_last_grant = r_last_grant;
  assign o_idle       = r_idle;

endmodule

// File: tb/tb_rr_channel_scheduler.sv
// Bench for rr_channel_scheduler (2 channels, 32->64, tag [55:48], MAX_BURST=4).
// Directed vector table, random run against a behavioural model, and burst-lock
// sequences when RR_BURST_LOCK_EN is defined.
module tb_rr_channel_scheduler;
  localparam int N  = 2;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [63:0] din;
  logic        ordy;
  logic [1:0]  rdy;
  logic [63:0] od;
  logic        ov;
  logic        lg;
  logic        idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_channel_scheduler #(
    .NUM_CHANNELS(N), .CHANNEL_WIDTH_IN(32), .CHANNEL_WIDTH_OUT(64),
    .TAG_MSB(55), .TAG_LSB(48), .MAX_BURST(MB)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_in_data(din), .i_in_valid(vld),
    .o_in_ready(rdy), .o_out_data(od), .o_out_valid(ov), .i_out_ready(ordy),
    .o_last_grant(lg), .o_idle(idle)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [31:0] d0,
                       input logic [31:0] d1, input logic o);
    rst = r; vld = v; din = {d1, d0}; ordy = o;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_ov;
  logic [63:0] m_od;
  int          m_lg;
  bit          m_idle;
  bit          m_lock;
  int          m_cnt;

  function automatic void m_arb(input logic [1:0] v, output bit hit, output int g);
    hit = 0; g = 0;
`ifdef RR_BURST_LOCK_EN
    if (m_lock && v[m_lg]) begin hit = 1; g = m_lg; return; end
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_lg + k) % N;
      if (!hit && v[c]) begin hit = 1; g = c; end
    end
  endfunction

  function automatic void m_step(input logic r, input logic [1:0] v, input logic [63:0] d,
                                 input logic o);
    bit hit; int g; bit le; bit xf; bit ovn;
    if (!r) begin
      m_ov = 0; m_od = '0; m_lg = N - 1; m_idle = 1; m_lock = 0; m_cnt = 0;
      return;
    end
    m_arb(v, hit, g);
    le  = !m_ov || o;
    xf  = le && hit;
    ovn = xf || (m_ov && !o);
    if (le) begin
      if (xf && m_lock && g == m_lg) begin
        m_cnt++;
        if (m_cnt == MB) begin m_lock = 0; m_cnt = 0; end
      end else if (xf) begin
        m_lock = (MB > 1); m_cnt = (MB > 1) ? 1 : 0;
      end else begin
        m_lock = 0; m_cnt = 0;
      end
    end
    if (xf) begin
      m_od = (64'(g) << 48) | 64'(d[g*32 +: 32]);
      m_lg = g;
    end
    m_ov   = ovn;
    m_idle = !ovn && (v == 2'b00);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ordy;
    logic [1:0]  e_rdy;
    logic        e_ov;
    logic [63:0] e_od;
    logic        e_lg;
    logic        e_idle;
  } vec_t;

  vec_t tbl[14];

  initial begin
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);

`ifndef RR_BURST_LOCK_EN
    tbl[0]  = '{1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 2'b11, 32'h1000_0001, 32'h2000_0001, 1'b1, 2'b01, 1'b1, 64'h0000_0000_1000_0001, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'b11, 32'h1000_0002, 32'h2000_0002, 1'b1, 2'b10, 1'b1, 64'h0001_0000_2000_0002, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'b11, 32'h1000_0003, 32'h2000_0003, 1'b1, 2'b01, 1'b1, 64'h0000_0000_1000_0003, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 32'hA5A5_A5A5, 32'h0,         1'b1, 2'b01, 1'b1, 64'h0000_0000_A5A5_A5A5, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b01, 32'h1111_1111, 32'h0,         1'b0, 2'b00, 1'b1, 64'h0000_0000_A5A5_A5A5, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 32'h1111_1111, 32'h0,         1'b0, 2'b00, 1'b1, 64'h0000_0000_A5A5_A5A5, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'b01, 32'h1111_1111, 32'h0,         1'b0, 2'b00, 1'b1, 64'h0000_0000_A5A5_A5A5, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 32'h1111_1111, 32'h0,         1'b1, 2'b01, 1'b1, 64'h0000_0000_1111_1111, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 32'h0,         32'h0,         1'b1, 2'b00, 1'b0, 64'h0000_0000_1111_1111, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 2'b10, 32'h0,         32'h2222_2222, 1'b0, 2'b10, 1'b1, 64'h0001_0000_2222_2222, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'b00, 32'h0,         32'h0,         1'b0, 2'b00, 1'b1, 64'h0001_0000_2222_2222, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'b00, 32'h0,         32'h0,         1'b1, 2'b00, 1'b0, 64'h0001_0000_2222_2222, 1'b1, 1'b1};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(rdy), 64'(tbl[i].e_rdy));
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 64'(ov), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i), od, tbl[i].e_od);
      chk($sformatf("tbl%0d_last_grant", i), 64'(lg), 64'(tbl[i].e_lg));
      chk($sformatf("tbl%0d_idle", i), 64'(idle), 64'(tbl[i].e_idle));
    end
`endif

    // ---------------- random run against the model ----------------
    for (int i = 0; i < 1500; i++) begin
      logic r; logic [1:0] v; logic [31:0] d0, d1; logic o;
      bit hit; int g; logic [1:0] e_rdy;
      r  = (i < 2) ? 1'b0 : (($urandom % 40) != 0);
      v  = 2'($urandom);
      d0 = $urandom; d1 = $urandom;
      o  = (($urandom % 4) != 0);
      drive(r, v, d0, d1, o);
      #1;
      m_arb(v, hit, g);
      e_rdy = (r && (!m_ov || o) && hit) ? (2'b01 << g) : 2'b00;
      chk("rand_in_ready", 64'(rdy), 64'(e_rdy));
      @(posedge clk);
      m_step(r, v, {d1, d0}, o);
      @(negedge clk);
      chk("rand_out_valid", 64'(ov), 64'(m_ov));
      chk("rand_out_data", od, m_od);
      chk("rand_last_grant", 64'(lg), 64'(m_lg));
      chk("rand_idle", 64'(idle), 64'(m_idle));
    end

`ifdef RR_BURST_LOCK_EN
    // Burst of MAX_BURST per channel with both channels valid
    begin
      int t4[9];
      t4 = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1); tick();
      for (int i = 0; i < 9; i++) begin
        drive(1'b1, 2'b11, 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b1); tick();
        chk($sformatf("burst4_valid%0d", i), 64'(ov), 64'd1);
        chk($sformatf("burst4_tag%0d", i), 64'(od[55:48]), 64'(t4[i]));
      end
    end
    // Locked channel drops valid: release with no bubble
    begin
      logic [1:0] v5[3];
      int t5[3];
      v5 = '{2'b11, 2'b11, 2'b10};
      t5 = '{0, 0, 1};
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1); tick();
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, v5[i], 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b1); tick();
        chk($sformatf("release_valid%0d", i), 64'(ov), 64'd1);
        chk($sformatf("release_tag%0d", i), 64'(od[55:48]), 64'(t5[i]));
      end
    end
    // Reset in the middle of a burst restarts at ch0 with a fresh count
    begin
      int t6[5];
      t6 = '{0, 0, 0, 0, 1};
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1); tick();
      for (int i = 0; i < 2; i++) begin
        drive(1'b1, 2'b11, 32'h500, 32'h600, 1'b1); tick();
      end
      drive(1'b0, 2'b11, 32'h500, 32'h600, 1'b1);
      #1;
      chk("midreset_in_ready", 64'(rdy), 64'd0);
      tick();
      chk("midreset_valid", 64'(ov), 64'd0);
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, 2'b11, 32'h700, 32'h800, 1'b1); tick();
        chk($sformatf("midreset_tag%0d", i), 64'(od[55:48]), 64'(t6[i]));
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
